// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with stall/bubble/flush, perf counters and hold watchdog
module pipe_stage_reg #(
    parameter int DATA_W      = 32,
    parameter int STALL_W     = 6,
    parameter int STAGE       = 4,
    parameter bit ZERO_BUBBLE = 1'b1,
    parameter int CNT_W       = 16,
    parameter int HOLD_LIMIT  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               cnt_clr,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic               hold_timeout
);

    // The downstream stall bit lives at STAGE+1, so the last vector slot cannot host a register.
    generate
        if (STAGE < 0 || STAGE > STALL_W - 2) begin : g_bad_stage
            $error("pipe_stage_reg: STAGE must be in 0..STALL_W-2");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } act_t;

    act_t act;

    // Only two bits of the global stall vector matter to this stage.
    logic unused_stall;
    assign unused_stall = ^stall;

    // Resolve this cycle's action in strict priority: flush, advance, bubble, hold.
    always_comb begin
        act = ACT_HOLD;
        if (flush)
            act = ACT_FLUSH;
        else if (!stall[STAGE])
            act = ACT_ADVANCE;
        else if (!stall[STAGE+1])
            act = ACT_BUBBLE;
        else
            act = ACT_HOLD;
    end

    // Payload and valid register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (act)
                ACT_ADVANCE: begin
                    out_valid <= in_valid;
                    out_data  <= in_data;
                end
                ACT_BUBBLE, ACT_FLUSH: begin
                    out_valid <= 1'b0;
                    if (ZERO_BUBBLE)
                        out_data <= '0;
                end
                default: ;
            endcase
        end
    end

    // Saturating performance counters; a clear wins over any increment on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
            flush_cnt  <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
            flush_cnt  <= '0;
        end else begin
            if (act == ACT_BUBBLE && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + 1'b1;
            if (act == ACT_HOLD && hold_cnt != CNT_MAX)
                hold_cnt <= hold_cnt + 1'b1;
            if (act == ACT_FLUSH && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    generate
        if (HOLD_LIMIT == 0) begin : g_no_wdog
            assign hold_timeout = 1'b0;
        end else begin : g_wdog
            localparam int RUN_W = $clog2(HOLD_LIMIT + 1);
            localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(HOLD_LIMIT);

            logic [RUN_W-1:0] run;
            logic [RUN_W-1:0] run_next;
            logic             timeout_q;

            // Consecutive-hold run length, pinned at the limit, dropped by any other action.
            always_comb begin
                run_next = '0;
                if (act == ACT_HOLD)
                    run_next = (run == RUN_LIM) ? run : run + 1'b1;
            end

            // Timeout is registered from the next run value so it shows right after the limiting edge.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    run       <= '0;
                    timeout_q <= 1'b0;
                end else begin
                    run       <= run_next;
                    timeout_q <= (run_next == RUN_LIM);
                end
            end

            assign hold_timeout = timeout_q;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - randomized model-checked bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        cnt_clr = 1'b0;

    logic        ov0, ht0, ov1, ht1;
    logic [31:0] od0, od1;
    logic [3:0]  bc0, hc0, fc0;
    logic [15:0] bc1, hc1, fc1;

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    // Reference state per instance: 0 = zeroing bubbles, CNT_W=4, limit 3; 1 = retaining, CNT_W=16, limit 64.
    bit          m_valid [2];
    logic [31:0] m_data  [2];
    int          m_b [2];
    int          m_h [2];
    int          m_f [2];
    int          m_streak [2];
    int          zb   [2] = '{1, 0};
    int          cmax [2] = '{15, 65535};
    int          hlim [2] = '{3, 64};

    pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(4), .ZERO_BUBBLE(1'b1), .CNT_W(4), .HOLD_LIMIT(3)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .cnt_clr(cnt_clr), .out_valid(ov0), .out_data(od0), .bubble_cnt(bc0), .hold_cnt(hc0),
        .flush_cnt(fc0), .hold_timeout(ht0)
    );

    pipe_stage_reg #(.DATA_W(32), .STALL_W(6), .STAGE(4), .ZERO_BUBBLE(1'b0), .CNT_W(16), .HOLD_LIMIT(64)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .cnt_clr(cnt_clr), .out_valid(ov1), .out_data(od1), .bubble_cnt(bc1), .hold_cnt(hc1),
        .flush_cnt(fc1), .hold_timeout(ht1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_data[i] = '0;
            m_b[i] = 0; m_h[i] = 0; m_f[i] = 0; m_streak[i] = 0;
        end
    endtask

    // One clock edge of the rules: classify the cycle, then apply outputs, counters, streak.
    task automatic model_edge();
        bit is_f, is_a, is_b, is_h;
        is_f = flush;
        is_a = !flush && !stall[4];
        is_b = !flush && stall[4] && !stall[5];
        is_h = !flush && stall[4] && stall[5];
        for (int i = 0; i < 2; i++) begin
            if (is_a) begin
                m_valid[i] = in_valid; m_data[i] = in_data;
            end else if (is_b || is_f) begin
                m_valid[i] = 1'b0;
                if (zb[i] != 0) m_data[i] = '0;
            end
            if (cnt_clr) begin
                m_b[i] = 0; m_h[i] = 0; m_f[i] = 0;
            end else begin
                if (is_b && m_b[i] < cmax[i]) m_b[i]++;
                if (is_h && m_h[i] < cmax[i]) m_h[i]++;
                if (is_f && m_f[i] < cmax[i]) m_f[i]++;
            end
            if (is_h) begin
                if (m_streak[i] <= hlim[i]) m_streak[i]++;
            end else begin
                m_streak[i] = 0;
            end
        end
    endtask

    function automatic logic exp_to(input int i);
        return (hlim[i] != 0) && (m_streak[i] >= hlim[i]);
    endfunction

    task automatic step(input logic [5:0] s, input logic f, input logic v, input logic [31:0] d, input logic c);
        stall = s; flush = f; in_valid = v; in_data = d; cnt_clr = c;
        @(posedge clk);
        if (rst) model_edge();
        #1;
    endtask

    // Every cycle, both instances are checked against the reference.
    always @(negedge clk) begin
        if (check_en) begin
            chk("d0.out_valid", 32'(ov0), 32'(m_valid[0]));
            chk("d0.out_data",  od0, m_data[0]);
            chk("d0.bubble_cnt", 32'(bc0), m_b[0]);
            chk("d0.hold_cnt",   32'(hc0), m_h[0]);
            chk("d0.flush_cnt",  32'(fc0), m_f[0]);
            chk("d0.hold_timeout", 32'(ht0), 32'(exp_to(0)));
            chk("d1.out_valid", 32'(ov1), 32'(m_valid[1]));
            chk("d1.out_data",  od1, m_data[1]);
            chk("d1.bubble_cnt", 32'(bc1), m_b[1]);
            chk("d1.hold_cnt",   32'(hc1), m_h[1]);
            chk("d1.flush_cnt",  32'(fc1), m_f[1]);
            chk("d1.hold_timeout", 32'(ht1), 32'(exp_to(1)));
        end
    end

    initial begin
        int burst;
        model_reset();
        check_en = 1'b1;
        #1;

        // Reset, then first advance
        step(6'b0, 1'b0, 1'b1, 32'h11111111, 1'b0);
        step(6'b0, 1'b0, 1'b1, 32'h22222222, 1'b0);
        chk("rst.out_valid", 32'(ov0), 32'h0);
        chk("rst.out_data", od0, 32'h0);
        chk("rst.hold_timeout", 32'(ht0), 32'h0);
        rst = 1'b1;
        step(6'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        chk("adv.out_data", od0, 32'hDEADBEEF);
        chk("adv.out_valid", 32'(ov0), 32'h1);

        // Bubble in both modes
        step(6'b0, 1'b0, 1'b1, 32'h12345678, 1'b0);
        step(6'b011111, 1'b0, 1'b1, 32'h0BADF00D, 1'b0);
        chk("bub.zero.out_valid", 32'(ov0), 32'h0);
        chk("bub.zero.out_data", od0, 32'h0);
        chk("bub.zero.bubble_cnt", 32'(bc0), 32'h1);
        chk("bub.keep.out_data", od1, 32'h12345678);
        chk("bub.keep.out_valid", 32'(ov1), 32'h0);

        // Hold with watchdog limit 3
        step(6'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(6'b111111, 1'b0, 1'b1, 32'h5A5A5A5A, 1'b0);
            chk("hold.out_data", od0, 32'hA5A5A5A5);
            chk("hold.timeout", 32'(ht0), (k >= 3) ? 32'h1 : 32'h0);
        end
        chk("hold.hold_cnt", 32'(hc0), 32'h5);
        step(6'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("hold.timeout_clear", 32'(ht0), 32'h0);

        // Flush beats an all-ones stall and resets the run
        step(6'b111111, 1'b0, 1'b1, 32'h0, 1'b0);
        step(6'b111111, 1'b0, 1'b1, 32'h0, 1'b0);
        step(6'b111111, 1'b1, 1'b1, 32'h77777777, 1'b0);
        chk("flush.out_valid", 32'(ov0), 32'h0);
        chk("flush.flush_cnt", 32'(fc0), 32'h1);
        chk("flush.hold_cnt", 32'(hc0), 32'h7);
        step(6'b111111, 1'b0, 1'b1, 32'h0, 1'b0);
        step(6'b111111, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("flush.run_reset", 32'(ht0), 32'h0);

        // Invalid input passes straight through
        step(6'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0);
        chk("inv.out_valid", 32'(ov0), 32'h0);
        chk("inv.out_data", od0, 32'hFFFFFFFF);
        chk("inv.bubble_cnt", 32'(bc0), 32'h1);
        chk("inv.hold_cnt", 32'(hc0), 32'h9);
        chk("inv.flush_cnt", 32'(fc0), 32'h1);

        // Saturation at 4 bits, then clear overriding a bubble
        for (int k = 0; k < 20; k++) step(6'b011111, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("sat.bubble_cnt", 32'(bc0), 32'hF);
        chk("sat.wide.bubble_cnt", 32'(bc1), 32'd21);
        step(6'b011111, 1'b0, 1'b1, 32'h0, 1'b1);
        chk("clr.bubble_cnt", 32'(bc0), 32'h0);
        chk("clr.hold_cnt", 32'(hc0), 32'h0);

        // Asynchronous reset in the middle of a hold
        step(6'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
        for (int k = 0; k < 4; k++) step(6'b111111, 1'b0, 1'b1, 32'h0, 1'b0);
        rst = 1'b0;
        model_reset();
        #1;
        chk("arst.out_valid", 32'(ov0), 32'h0);
        chk("arst.out_data", od0, 32'h0);
        chk("arst.hold_timeout", 32'(ht0), 32'h0);
        step(6'b111111, 1'b0, 1'b1, 32'h0, 1'b0);
        rst = 1'b1;

        // Randomized traffic with long hold bursts to reach both watchdog limits
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] s;
            logic f;
            if (($urandom % 250) == 0) begin
                rst = 1'b0;
                model_reset();
            end else begin
                rst = 1'b1;
            end
            if (burst == 0 && ($urandom % 40) == 0) burst = $urandom_range(2, 80);
            s = 6'($urandom);
            f = (($urandom % 16) == 0);
            if (burst > 0) begin
                s[5:4] = 2'b11;
                f = (($urandom % 64) == 0);
                burst--;
            end
            step(s, f, 1'($urandom), $urandom, (($urandom % 32) == 0));
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the CPU's six-entry stall-vector pipeline. It is the general successor to the fixed inter-stage latches. It carries a DATA_W-bit payload plus a valid bit from one stage to the next, honours stall, bubble and flush, and selects between zeroing and valid-only bubble modes. It also keeps saturating per-stage performance counters and a consecutive-hold watchdog used by debug and the stall controller.

## Interface
Parameters:
- DATA_W, 32: payload width in bits (≥1).
- STALL_W, 6: width of the global stall vector.
- STAGE, 4: index of this register's upstream stage in stall; legal range 0..STALL_W-2.
- ZERO_BUBBLE, 1: 1 = bubble/flush zero out_data; 0 = out_data retained, only out_valid cleared.
- CNT_W, 16: width of each performance counter.
- HOLD_LIMIT, 64: consecutive hold cycles that raise hold_timeout; 0 disables the watchdog (output tied 0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- stall  in  STALL_W  global stall vector; stall[STAGE] = upstream stalled, stall[STAGE+1] = downstream stalled.
- flush  in  1  exception flush; synchronous.
- in_valid  in  1  upstream stage result is valid.
- in_data  in  DATA_W  upstream payload.
- cnt_clr  in  1  synchronous clear of all performance counters.
- out_valid  out  1  registered valid to downstream stage.
- out_data  out  DATA_W  registered payload.
- bubble_cnt  out  CNT_W  count of bubble-insert cycles, saturating.
- hold_cnt  out  CNT_W  count of hold cycles, saturating.
- flush_cnt  out  CNT_W  count of flush cycles, saturating.
- hold_timeout  out  1  level; consecutive-hold watchdog tripped.

## Operation
- Per-cycle action, strict priority:
  - FLUSH: flush=1.
  - ADVANCE: stall[STAGE]=0.
  - BUBBLE: stall[STAGE]=1 and stall[STAGE+1]=0.
  - HOLD: stall[STAGE]=1 and stall[STAGE+1]=1.
- ADVANCE: out_data<=in_data, out_valid<=in_valid. An invalid input is passed through as-is.
- BUBBLE and FLUSH: out_valid<=0. out_data<=0 if ZERO_BUBBLE=1, else out_data is unchanged.
- HOLD: out_valid and out_data are unchanged.
- Performance counters:
  - bubble_cnt, hold_cnt and flush_cnt each increment by 1 in a cycle of their action.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - Flush does not clear the counters.
  - cnt_clr=1 forces all three to 0 that edge, overriding any simultaneous increment.
- Watchdog:
  - Internal run counter is ceil(log2(HOLD_LIMIT+1)) bits wide.
  - It increments on each HOLD cycle, saturating at HOLD_LIMIT.
  - Any non-HOLD action resets it to 0.
  - hold_timeout = registered (run == HOLD_LIMIT). It stays 1 while holds continue and clears on the edge of the first non-HOLD action.
- cnt_clr does not affect the run counter or hold_timeout.

## Timing
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, all counters=0, run=0, hold_timeout=0. Reset overrides every other input, including mid-hold.
- Latency is 1 cycle in → out on ADVANCE. There is no combinational path from any input to any output.
- STAGE = STALL_W-1 is illegal. The implementation must flag it with an elaboration-time error.
- Flush with stall all-ones still clears out_valid and counts only in flush_cnt; hold_cnt and run are not incremented.
- A bubble following a hold counts as one bubble, and run returns to 0.
- hold_timeout first reads 1 in the cycle after the HOLD_LIMIT-th consecutive HOLD edge.

## Test plan
- Reset/advance:
  - Stimulus: assert rst=0 mid-stream; release; drive stall=0, in_valid=1, in_data=32'hDEADBEEF.
  - Required: all outputs read 0 during reset; out_data=32'hDEADBEEF and out_valid=1 one edge after release.
- Bubble, ZERO_BUBBLE=1:
  - Stimulus: load 32'h12345678; set stall=6'b011111 (STAGE=4: stall[4]=1, stall[5]=0).
  - Required: next edge out_valid=0, out_data=0, bubble_cnt=1.
  - Repeat with ZERO_BUBBLE=0: out_data stays 32'h12345678, out_valid=0.
- Hold and watchdog, HOLD_LIMIT=3:
  - Stimulus: load 32'hA5A5A5A5; set stall=6'b111111 for 5 cycles, then stall=0.
  - Required: data held throughout; hold_timeout=1 after the 3rd hold edge; hold_cnt=5; hold_timeout=0 after the advance edge.
- Flush priority:
  - Stimulus: flush=1 with stall=6'b111111 and in_valid=1.
  - Required: out_valid=0, flush_cnt=1, hold_cnt unchanged, run=0.
- Counter saturation and clear, CNT_W=4:
  - Stimulus: 20 bubble cycles.
  - Required: bubble_cnt=15 and stays there.
  - Then cnt_clr=1 together with a bubble cycle: bubble_cnt=0.
- Invalid passthrough:
  - Stimulus: stall=0, in_valid=0, in_data=32'hFFFFFFFF.
  - Required: out_valid=0, out_data=32'hFFFFFFFF; no counter changes.
